rfphoenix_wb_sequencer: RTL and testbench

Producer side of the scoreboard release/rollback interface. Collects completions from NUM_FU functional units, buffers them per unit, and round-robin arbitrates them onto the single register writeback port (wb_v/wb_Rt/wb_res). Tracks in-flight targets from issue to writeback. On flush it emits the one-cycle rollback pulse with the in-flight bitmap, and discards stale results using an epoch bit.

---
 rtl/rfphoenix_wb_sequencer.sv | 157 +++++++++++++++
 tb/tb_rfphoenix_wb_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rfphoenix_wb_sequencer.sv
// Writeback sequencer: buffers FU completions per unit, round-robin arbitrates them onto
// the single writeback port, tracks in-flight targets and produces the flush rollback pulse.
module rfphoenix_wb_sequencer #(
  parameter int NUM_FU     = 4,
  parameter int DW         = 64,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_v,
  input  logic [6:0]           issue_Rt,
  output logic                 cur_epoch,
  input  logic [NUM_FU-1:0]    fu_v,
  output logic [NUM_FU-1:0]    fu_rdy,
  input  logic [NUM_FU*7-1:0]  fu_Rt,
  input  logic [NUM_FU-1:0]    fu_epoch,
  input  logic [NUM_FU*DW-1:0] fu_res,
  input  logic                 flush,
  output logic                 wb_v,
  output logic [6:0]           wb_Rt,
  output logic [DW-1:0]        wb_res,
  output logic                 rollback,
  output logic [127:0]         rollback_bitmap,
  output logic [127:0]         inflight,
  output logic                 err_orphan
);

  localparam int RW = $clog2(NUM_FU);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [6:0]    rt_mem  [NUM_FU][FIFO_DEPTH];
  logic [DW-1:0] res_mem [NUM_FU][FIFO_DEPTH];
  logic [PW-1:0] rd_ptr  [NUM_FU];
  logic [PW-1:0] wr_ptr  [NUM_FU];
  logic [CW-1:0] count   [NUM_FU];
  logic [CW-1:0] cnt_nxt [NUM_FU];

  logic [RW-1:0]     rr_ptr;
  logic [RW-1:0]     gnt_idx;
  logic              gnt_found;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;
  logic [6:0]        head_rt;
  logic [DW-1:0]     head_res;
  logic [127:0]      inflight_nxt;
  logic              orphan_now;

  function automatic logic [RW-1:0] rr_add(input logic [RW-1:0] base, input int off);
    int s;
    s = (int'(base) + off) % NUM_FU;
    return RW'(s);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == FIFO_DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  // Grant the first non-empty FIFO scanning upward from the round-robin pointer.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int off = 0; off < NUM_FU; off++) begin
      if (!gnt_found && count[rr_add(rr_ptr, off)] != '0) begin
        gnt_found = 1'b1;
        gnt_idx   = rr_add(rr_ptr, off);
      end
    end
    head_rt  = rt_mem[gnt_idx][rd_ptr[gnt_idx]];
    head_res = res_mem[gnt_idx][rd_ptr[gnt_idx]];
  end

  // Results carrying an old epoch are dropped at the door; a flush discards everything.
  always_comb begin
    push = '0;
    pop  = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      push[i]    = fu_v[i] && fu_rdy[i] && (fu_epoch[i] == cur_epoch) && !flush;
      pop[i]     = gnt_found && (gnt_idx == RW'(i)) && !flush;
      cnt_nxt[i] = count[i] + CW'(push[i]) - CW'(pop[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fu_rdy <= '1;
      for (int i = 0; i < NUM_FU; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else if (flush) begin
      fu_rdy <= '1;
      for (int i = 0; i < NUM_FU; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push[i]) wr_ptr[i] <= ptr_inc(wr_ptr[i]);
        if (pop[i])  rd_ptr[i] <= ptr_inc(rd_ptr[i]);
        count[i]  <= cnt_nxt[i];
        fu_rdy[i] <= (cnt_nxt[i] != CW'(FIFO_DEPTH));
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i]) begin
        rt_mem[i][wr_ptr[i]]  <= fu_Rt[i*7 +: 7];
        res_mem[i][wr_ptr[i]] <= fu_res[i*DW +: DW];
      end
    end
  end

  // A same-cycle issue of the written-back target wins over the clear and masks the orphan check.
  always_comb begin
    inflight_nxt = inflight;
    if (wb_v) inflight_nxt[wb_Rt] = 1'b0;
    if (issue_v && issue_Rt != 7'd0) inflight_nxt[issue_Rt] = 1'b1;
    if (flush) inflight_nxt = '0;
    orphan_now = wb_v && !inflight[wb_Rt] && !(issue_v && !flush && issue_Rt == wb_Rt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_v            <= 1'b0;
      wb_Rt           <= '0;
      wb_res          <= '0;
      rollback        <= 1'b0;
      rollback_bitmap <= '0;
      inflight        <= '0;
      cur_epoch       <= 1'b0;
      err_orphan      <= 1'b0;
      rr_ptr          <= '0;
    end else begin
      rollback        <= flush;
      rollback_bitmap <= flush ? inflight : '0;
      inflight        <= inflight_nxt;
      err_orphan      <= err_orphan | orphan_now;
      if (flush) begin
        cur_epoch <= ~cur_epoch;
        wb_v      <= 1'b0;
      end else begin
        wb_v <= gnt_found && (head_rt != 7'd0);
        if (gnt_found && head_rt != 7'd0) begin
          wb_Rt  <= head_rt;
          wb_res <= head_res;
        end
        if (gnt_found) rr_ptr <= rr_add(gnt_idx, 1);
      end
    end
  end

endmodule

// File: tb/tb_rfphoenix_wb_sequencer.sv
// Bench for rfphoenix_wb_sequencer: directed scenarios then random traffic, every cycle
// compared against a queue-based reference model of the writeback sequencer.
module tb_rfphoenix_wb_sequencer;

  localparam int NUM_FU = 4;
  localparam int DW     = 64;
  localparam int DEPTH  = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 issue_v;
  logic [6:0]           issue_Rt;
  logic                 cur_epoch;
  logic [NUM_FU-1:0]    fu_v;
  logic [NUM_FU-1:0]    fu_rdy;
  logic [NUM_FU*7-1:0]  fu_Rt;
  logic [NUM_FU-1:0]    fu_epoch;
  logic [NUM_FU*DW-1:0] fu_res;
  logic                 flush;
  logic                 wb_v;
  logic [6:0]           wb_Rt;
  logic [DW-1:0]        wb_res;
  logic                 rollback;
  logic [127:0]         rollback_bitmap;
  logic [127:0]         inflight;
  logic                 err_orphan;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [6+DW:0]     mq [NUM_FU][$];
  logic              m_wbv, m_rb, m_ep, m_orph;
  logic [6:0]        m_wbrt;
  logic [DW-1:0]     m_wbres;
  logic [127:0]      m_rbmap, m_inf;
  logic [NUM_FU-1:0] m_rdy;
  int                m_rr;

  rfphoenix_wb_sequencer #(.NUM_FU(NUM_FU), .DW(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .issue_v(issue_v), .issue_Rt(issue_Rt), .cur_epoch(cur_epoch),
    .fu_v(fu_v), .fu_rdy(fu_rdy), .fu_Rt(fu_Rt), .fu_epoch(fu_epoch), .fu_res(fu_res),
    .flush(flush), .wb_v(wb_v), .wb_Rt(wb_Rt), .wb_res(wb_res), .rollback(rollback),
    .rollback_bitmap(rollback_bitmap), .inflight(inflight), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wbv = 0; m_rb = 0; m_ep = 0; m_orph = 0;
    m_wbrt = 0; m_wbres = 0; m_rbmap = 0; m_inf = 0;
    m_rdy = '1; m_rr = 0;
    for (int i = 0; i < NUM_FU; i++) mq[i].delete();
  endtask

  // Advance the reference model by one clock edge from the inputs now being driven.
  task automatic model_update();
    logic          found;
    logic [6+DW:0] e;
    if (m_wbv && !m_inf[m_wbrt] && !(issue_v && !flush && issue_Rt == m_wbrt)) m_orph = 1;
    if (flush) begin
      m_rb = 1; m_rbmap = m_inf; m_inf = 0; m_ep = ~m_ep; m_wbv = 0; m_rdy = '1;
      for (int i = 0; i < NUM_FU; i++) mq[i].delete();
    end else begin
      m_rb = 0; m_rbmap = 0;
      if (m_wbv) m_inf[m_wbrt] = 0;
      if (issue_v && issue_Rt != 0) m_inf[issue_Rt] = 1;
      found = 0; e = '0;
      for (int k = 0; k < NUM_FU; k++) begin
        int j;
        j = (m_rr + k) % NUM_FU;
        if (!found && mq[j].size() > 0) begin
          found = 1; e = mq[j].pop_front(); m_rr = (j + 1) % NUM_FU;
        end
      end
      m_wbv = found && (e[6+DW:DW] != 0);
      if (m_wbv) begin m_wbrt = e[6+DW:DW]; m_wbres = e[DW-1:0]; end
      for (int i = 0; i < NUM_FU; i++)
        if (fu_v[i] && m_rdy[i] && fu_epoch[i] == m_ep)
          mq[i].push_back({fu_Rt[i*7 +: 7], fu_res[i*DW +: DW]});
      for (int i = 0; i < NUM_FU; i++) m_rdy[i] = (mq[i].size() < DEPTH);
    end
  endtask

  task automatic checkOutput();
    chk("wb_v", wb_v, m_wbv);
    chk("wb_Rt", wb_Rt, m_wbrt);
    chk("wb_res", wb_res, m_wbres);
    chk("rollback", rollback, m_rb);
    chk("rollback_bitmap", rollback_bitmap, m_rbmap);
    chk("inflight", inflight, m_inf);
    chk("cur_epoch", cur_epoch, m_ep);
    chk("err_orphan", err_orphan, m_orph);
    chk("fu_rdy", fu_rdy, m_rdy);
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic clear_in();
    issue_v = 0; issue_Rt = 0; fu_v = '0; flush = 0;
  endtask

  task automatic do_issue(input int rt);
    issue_v = 1; issue_Rt = 7'(rt);
    step();
    issue_v = 0; issue_Rt = 0;
  endtask

  task automatic set_fu(input int i, input int rt, input logic [DW-1:0] res);
    fu_v[i] = 1; fu_Rt[i*7 +: 7] = 7'(rt); fu_res[i*DW +: DW] = res; fu_epoch[i] = m_ep;
  endtask

  initial begin
    logic [127:0] exp_map;
    logic [6:0]   pool [8];
    int           idx, n2;
    logic         saw_stall, acc;

    rst = 1; fu_Rt = '0; fu_res = '0; fu_epoch = '0;
    clear_in();
    model_reset();
    @(posedge clk); #1;
    checkOutput();
    rst = 0;

    // single path
    do_issue(5);
    step(); step();
    set_fu(0, 5, 64'hAB); step(); clear_in();
    step();
    chk("single_wbv", wb_v, 1); chk("single_rt", wb_Rt, 5); chk("single_res", wb_res, 64'hAB);
    step();
    chk("single_clr", inflight[5], 0); chk("single_orphan", err_orphan, 0);

    // Rt=0 on FU3 pops silently and leaves the pointer at FU0
    set_fu(3, 0, 64'h77); step(); clear_in();
    step();
    chk("r0_wbv", wb_v, 0); chk("r0_inflight", inflight, 0);

    // contention, twice
    for (int b = 0; b < 2; b++) begin
      for (int r = 1; r <= 4; r++) do_issue(r);
      for (int f = 0; f < 4; f++) set_fu(f, f + 1, 64'(16 * b + f));
      step(); clear_in();
      for (int k = 1; k <= 4; k++) begin
        step();
        chk("cont_v", wb_v, 1); chk("cont_order", wb_Rt, k);
      end
    end

    // backpressure on FU2 against a steady FU0 stream
    for (int r = 11; r <= 13; r++) do_issue(r);
    idx = 0; n2 = 0; saw_stall = 0;
    for (int c = 0; c < 16; c++) begin
      fu_v = '0;
      if (c < 8) set_fu(0, 0, 64'(c));
      if (idx < 3) set_fu(2, 11 + idx, 64'(512 + idx));
      acc = (idx < 3) && fu_rdy[2];
      step();
      if (acc) idx++;
      if (!fu_rdy[2]) saw_stall = 1;
      if (wb_v && wb_Rt >= 11 && wb_Rt <= 13) n2++;
    end
    clear_in();
    chk("bp_stall", saw_stall, 1); chk("bp_accepts", idx, 3); chk("bp_all_fu2", n2, 3);

    // same-cycle set and clear
    do_issue(3);
    set_fu(1, 3, 64'h33); step(); clear_in();
    step();
    chk("sc_wb", wb_Rt, 3);
    do_issue(3);
    chk("sc_inflight", inflight[3], 1); chk("sc_orphan", err_orphan, 0);
    set_fu(1, 3, 64'h34); step(); clear_in();
    step(); step();
    chk("sc_drained", inflight, 0);

    // flush with three targets in flight, then a stale completion
    do_issue(7); do_issue(9); do_issue(12);
    flush = 1; step(); flush = 0;
    exp_map = '0; exp_map[7] = 1; exp_map[9] = 1; exp_map[12] = 1;
    chk("fl_pulse", rollback, 1); chk("fl_map", rollback_bitmap, exp_map);
    chk("fl_inflight", inflight, 0); chk("fl_epoch", cur_epoch, 1);
    step();
    chk("fl_pulse_end", rollback, 0); chk("fl_map_end", rollback_bitmap, 0);
    set_fu(1, 9, 64'h99); fu_epoch[1] = 0; step(); clear_in();
    step(); chk("stale_1", wb_v, 0);
    step(); chk("stale_2", wb_v, 0);

    // orphan writeback is sticky
    set_fu(2, 20, 64'h55); step(); clear_in();
    step();
    chk("orph_wbv", wb_v, 1); chk("orph_rt", wb_Rt, 20);
    step(); chk("orph_set", err_orphan, 1);
    step(); step(); chk("orph_sticky", err_orphan, 1);

    // asynchronous reset mid-operation
    issue_v = 1; issue_Rt = 40; set_fu(0, 41, 64'h41); step(); clear_in();
    #2 rst = 1;
    model_reset();
    #1;
    checkOutput();
    chk("rst_orphan", err_orphan, 0); chk("rst_rollback", rollback, 0);
    @(posedge clk); #1;
    checkOutput();
    rst = 0;

    // random traffic
    for (int p = 0; p < 8; p++) pool[p] = 7'($urandom_range(1, 127));
    for (int c = 0; c < 400; c++) begin
      clear_in();
      if ($urandom_range(0, 1) == 1) begin
        issue_v = 1; issue_Rt = pool[$urandom_range(0, 7)];
        if ($urandom_range(0, 7) == 0) pool[$urandom_range(0, 7)] = 7'($urandom);
      end
      for (int f = 0; f < NUM_FU; f++) begin
        if ($urandom_range(0, 9) < 4) begin
          set_fu(f, ($urandom_range(0, 5) == 0) ? int'(7'($urandom)) : int'(pool[$urandom_range(0, 7)]),
                 {$urandom, $urandom});
          if ($urandom_range(0, 9) == 0) fu_epoch[f] = ~m_ep;
        end
      end
      flush = ($urandom_range(0, 31) == 0);
      step();
    end
    clear_in();
    for (int c = 0; c < 12; c++) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
